// File: rtl/idex_stage_buf_pkg.sv
// Shared constants for the decode->execute stage buffer: flush source indices and default widths.
package idex_pkg;
   localparam int FLUSH_HAZ     = 0;
   localparam int FLUSH_INT     = 1;
   localparam int DEF_DATA_W    = 64;
   localparam int DEF_CTRL_W    = 16;
   localparam int DEF_PC_W      = 32;
   localparam int DEF_NUM_FLUSH = 2;
endpackage

// File: rtl/idex_stage_buf_entry.sv
// One storage slot of the stage buffer. Ctrl is zeroed whenever the slot is invalid so it can drive
// the execute stage directly; data and pc keep their last value.
module idex_entry #(
   parameter int CTRL_W = 16,
   parameter int DATA_W = 64,
   parameter int PC_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              clear,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   input  logic [PC_W-1:0]   in_pc,
   output logic              valid,
   output logic [CTRL_W-1:0] ctrl,
   output logic [DATA_W-1:0] data,
   output logic [PC_W-1:0]   pc
);
   logic              valid_d, valid_q;
   logic [CTRL_W-1:0] ctrl_d, ctrl_q;
   logic [DATA_W-1:0] data_d, data_q;
   logic [PC_W-1:0]   pc_d, pc_q;

   // slot next-state: load wins over clear, otherwise hold
   always_comb begin
      valid_d = valid_q;
      ctrl_d  = ctrl_q;
      data_d  = data_q;
      pc_d    = pc_q;
      if (load) begin
         valid_d = 1'b1;
         ctrl_d  = in_ctrl;
         data_d  = in_data;
         pc_d    = in_pc;
      end else if (clear) begin
         valid_d = 1'b0;
         ctrl_d  = '0;
      end else begin
         valid_d = valid_q;
      end
   end

   // slot registers
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         ctrl_q  <= '0;
         data_q  <= '0;
         pc_q    <= '0;
      end else begin
         valid_q <= valid_d;
         ctrl_q  <= ctrl_d;
         data_q  <= data_d;
         pc_q    <= pc_d;
      end
   end

   assign valid = valid_q;
   assign ctrl  = ctrl_q;
   assign data  = data_q;
   assign pc    = pc_q;
endmodule

// File: rtl/idex_stage_buf.sv
// Decode->execute pipeline stage: head slot plus optional skid slot, valid/ready handshake,
// multi-source flush and a registered report of the oldest killed instruction's PC.
module idex_stage_buf import idex_pkg::*; #(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int CTRL_W    = DEF_CTRL_W,
   parameter int PC_W      = DEF_PC_W,
   parameter int NUM_FLUSH = DEF_NUM_FLUSH,
   parameter int SKID      = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [CTRL_W-1:0]    in_ctrl,
   input  logic [DATA_W-1:0]    in_data,
   input  logic [PC_W-1:0]      in_pc,
   input  logic [NUM_FLUSH-1:0] flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [CTRL_W-1:0]    out_ctrl,
   output logic [DATA_W-1:0]    out_data,
   output logic [PC_W-1:0]      out_pc,
   output logic                 kill_valid,
   output logic [PC_W-1:0]      kill_pc,
   output logic [NUM_FLUSH-1:0] kill_src
);
   logic              h_v, s_v;
   logic [CTRL_W-1:0] h_ctrl, s_ctrl;
   logic [DATA_W-1:0] h_data, s_data;
   logic [PC_W-1:0]   h_pc, s_pc;
   logic              acc, rel, fl;
   logic              h_load, h_clear, h_from_skid, s_load, s_clear, s_v_next;
   logic              in_ready_d, in_ready_q;
   logic                 kill_valid_d, kill_valid_q;
   logic [PC_W-1:0]      kill_pc_d, kill_pc_q;
   logic [NUM_FLUSH-1:0] kill_src_d, kill_src_q;

   assign in_ready = (SKID != 0) ? in_ready_q : (out_ready | ~h_v);
   assign acc      = in_valid & in_ready;
   assign rel      = h_v & out_ready;
   assign fl       = |flush;

   // slot movement: a free or releasing head refills from skid first, then from the input
   always_comb begin
      h_load      = 1'b0;
      h_clear     = 1'b0;
      h_from_skid = 1'b0;
      s_load      = 1'b0;
      s_clear     = 1'b0;
      s_v_next    = s_v;
      if (fl) begin
         h_clear  = 1'b1;
         s_clear  = 1'b1;
         s_v_next = 1'b0;
      end else if (!h_v || rel) begin
         if (s_v) begin
            h_load      = 1'b1;
            h_from_skid = 1'b1;
            s_load      = acc;
            s_clear     = ~acc;
            s_v_next    = acc;
         end else if (acc) begin
            h_load   = 1'b1;
            s_clear  = 1'b1;
            s_v_next = 1'b0;
         end else begin
            h_clear  = 1'b1;
            s_clear  = 1'b1;
            s_v_next = 1'b0;
         end
      end else begin
         s_load   = acc;
         s_v_next = s_v | acc;
      end
      in_ready_d = ~s_v_next;
   end

   // kill report: oldest surviving candidate is unreleased head, then skid, then the accepted input
   always_comb begin
      kill_valid_d = 1'b0;
      kill_pc_d    = '0;
      kill_src_d   = '0;
      if (fl) begin
         if (h_v && !rel) begin
            kill_valid_d = 1'b1;
            kill_pc_d    = h_pc;
         end else if (s_v) begin
            kill_valid_d = 1'b1;
            kill_pc_d    = s_pc;
         end else if (acc) begin
            kill_valid_d = 1'b1;
            kill_pc_d    = in_pc;
         end else begin
            kill_valid_d = 1'b0;
         end
         kill_src_d = kill_valid_d ? flush : '0;
      end else begin
         kill_valid_d = 1'b0;
      end
   end

   // handshake and kill-report registers
   always_ff @(posedge clk) begin
      if (rst) begin
         in_ready_q   <= 1'b1;
         kill_valid_q <= 1'b0;
         kill_pc_q    <= '0;
         kill_src_q   <= '0;
      end else begin
         in_ready_q   <= in_ready_d;
         kill_valid_q <= kill_valid_d;
         kill_pc_q    <= kill_pc_d;
         kill_src_q   <= kill_src_d;
      end
   end

   idex_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .PC_W(PC_W)) u_head (
      .clk(clk), .rst(rst), .load(h_load), .clear(h_clear),
      .in_ctrl(h_from_skid ? s_ctrl : in_ctrl),
      .in_data(h_from_skid ? s_data : in_data),
      .in_pc(h_from_skid ? s_pc : in_pc),
      .valid(h_v), .ctrl(h_ctrl), .data(h_data), .pc(h_pc)
   );

   if (SKID != 0) begin : g_skid
      idex_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .PC_W(PC_W)) u_skid (
         .clk(clk), .rst(rst), .load(s_load), .clear(s_clear),
         .in_ctrl(in_ctrl), .in_data(in_data), .in_pc(in_pc),
         .valid(s_v), .ctrl(s_ctrl), .data(s_data), .pc(s_pc)
      );
   end else begin : g_noskid
      assign s_v    = 1'b0;
      assign s_ctrl = '0;
      assign s_data = '0;
      assign s_pc   = '0;
   end

   assign out_valid  = h_v;
   assign out_ctrl   = h_ctrl;
   assign out_data   = h_data;
   assign out_pc     = h_pc;
   assign kill_valid = kill_valid_q;
   assign kill_pc    = kill_pc_q;
   assign kill_src   = kill_src_q;
endmodule

// File: tb/tb_idex_stage_buf.sv
// Scoreboard bench: one SKID=1 and one SKID=0 instance share stimulus; each has a queue model of
// stage contents and a monitor comparing releases, idle outputs, in_ready and kill reports.
module tb_idex_stage_buf;
   typedef struct {
      logic [31:0] pc;
      logic [15:0] ctrl;
      logic [63:0] data;
   } entry_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [15:0] in_ctrl;
   logic [63:0] in_data;
   logic [31:0] in_pc;
   logic [1:0]  flush;
   logic        out_ready;
   int          vectors = 0;
   int          miscompares = 0;

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int SK = (g == 0) ? 1 : 0;
      logic        in_ready, out_valid, kill_valid;
      logic [15:0] out_ctrl;
      logic [63:0] out_data;
      logic [31:0] out_pc, kill_pc;
      logic [1:0]  kill_src;
      entry_t      q[$];
      logic        kill_pend = 1'b0;
      logic [31:0] kill_pc_e;
      logic [1:0]  kill_src_e;
      bit          seen_rst = 1'b0;

      idex_stage_buf #(.SKID(SK)) dut (
         .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
         .in_ctrl(in_ctrl), .in_data(in_data), .in_pc(in_pc), .flush(flush),
         .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
         .out_data(out_data), .out_pc(out_pc), .kill_valid(kill_valid),
         .kill_pc(kill_pc), .kill_src(kill_src)
      );

      always @(negedge clk) begin
         entry_t e;
         logic   rel, acc;
         if (seen_rst) begin
            chk($sformatf("s%0d_out_valid", SK), 64'(out_valid), 64'(q.size() != 0));
            if (q.size() == 0) chk($sformatf("s%0d_idle_ctrl", SK), 64'(out_ctrl), 64'd0);
            chk($sformatf("s%0d_in_ready", SK), 64'(in_ready),
                64'((SK != 0) ? (q.size() < 2) : (out_ready || q.size() == 0)));
            chk($sformatf("s%0d_kill_valid", SK), 64'(kill_valid), 64'(kill_pend));
            if (kill_pend) begin
               chk($sformatf("s%0d_kill_pc", SK), 64'(kill_pc), 64'(kill_pc_e));
               chk($sformatf("s%0d_kill_src", SK), 64'(kill_src), 64'(kill_src_e));
            end
         end
         rel = (q.size() != 0) && out_ready;
         acc = in_valid && in_ready;
         if (rst) begin
            q.delete();
            kill_pend = 1'b0;
            seen_rst  = 1'b1;
         end else if (seen_rst) begin
            if (rel) begin
               e = q.pop_front();
               chk($sformatf("s%0d_out_pc", SK), 64'(out_pc), 64'(e.pc));
               chk($sformatf("s%0d_out_ctrl", SK), 64'(out_ctrl), 64'(e.ctrl));
               chk($sformatf("s%0d_out_data", SK), out_data, e.data);
            end
            kill_pend = 1'b0;
            if (flush != 2'b00) begin
               if (q.size() != 0) begin
                  kill_pend = 1'b1;
                  kill_pc_e = q[0].pc;
               end else if (acc) begin
                  kill_pend = 1'b1;
                  kill_pc_e = in_pc;
               end
               kill_src_e = flush;
               q.delete();
            end else if (acc) begin
               e.pc   = in_pc;
               e.ctrl = in_ctrl;
               e.data = in_data;
               q.push_back(e);
            end
         end
      end
   end

   task automatic cyc(input logic v, input logic [31:0] pc, input logic ordy, input logic [1:0] fl);
      in_valid  = v;
      in_pc     = pc;
      in_ctrl   = 16'($urandom);
      in_data   = {$urandom, $urandom};
      out_ready = ordy;
      flush     = fl;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b1; in_pc = 32'h0; in_ctrl = 16'hffff;
      in_data = 64'h0; out_ready = 1'b1; flush = 2'b00;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(g_inst[0].out_valid), 64'd0);
      chk("rst_out_ctrl", 64'(g_inst[0].out_ctrl), 64'd0);
      chk("rst_in_ready", 64'(g_inst[0].in_ready), 64'd1);
      chk("rst_kill_valid", 64'(g_inst[0].kill_valid), 64'd0);
      rst = 1'b0;
      // stream
      cyc(1'b1, 32'h100, 1'b1, 2'b00);
      cyc(1'b1, 32'h104, 1'b1, 2'b00);
      cyc(1'b1, 32'h108, 1'b1, 2'b00);
      repeat (2) cyc(1'b0, 32'h0, 1'b1, 2'b00);
      // backpressure
      cyc(1'b1, 32'h200, 1'b0, 2'b00);
      cyc(1'b1, 32'h204, 1'b0, 2'b00);
      cyc(1'b0, 32'h0, 1'b0, 2'b00);
      repeat (3) cyc(1'b0, 32'h0, 1'b1, 2'b00);
      // interrupt flush with head and skid occupied
      cyc(1'b1, 32'h300, 1'b0, 2'b00);
      cyc(1'b1, 32'h304, 1'b0, 2'b00);
      cyc(1'b0, 32'h0, 1'b0, 2'b10);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("irq%0d_out_valid", i), 64'(i == 0 ? g_inst[0].out_valid : g_inst[1].out_valid), 64'd0);
         chk($sformatf("irq%0d_kill_valid", i), 64'(i == 0 ? g_inst[0].kill_valid : g_inst[1].kill_valid), 64'd1);
         chk($sformatf("irq%0d_kill_pc", i), 64'(i == 0 ? g_inst[0].kill_pc : g_inst[1].kill_pc), 64'h300);
         chk($sformatf("irq%0d_kill_src", i), 64'(i == 0 ? g_inst[0].kill_src : g_inst[1].kill_src), 64'h2);
      end
      repeat (2) cyc(1'b0, 32'h0, 1'b1, 2'b00);
      // flush empty stage with and without input
      cyc(1'b1, 32'h400, 1'b1, 2'b01);
      chk("empty_in_kill_pc", 64'(g_inst[0].kill_pc), 64'h400);
      cyc(1'b0, 32'h0, 1'b1, 2'b01);
      chk("empty_noin_kill_valid", 64'(g_inst[0].kill_valid), 64'd0);
      cyc(1'b0, 32'h0, 1'b1, 2'b00);
      // back-to-back flushes
      cyc(1'b1, 32'h500, 1'b0, 2'b00);
      cyc(1'b1, 32'h504, 1'b0, 2'b01);
      cyc(1'b1, 32'h508, 1'b0, 2'b11);
      cyc(1'b0, 32'h0, 1'b1, 2'b00);
      // reset mid-operation, together with a flush
      cyc(1'b1, 32'h600, 1'b0, 2'b00);
      rst = 1'b1;
      cyc(1'b1, 32'h604, 1'b0, 2'b10);
      rst = 1'b0;
      cyc(1'b0, 32'h0, 1'b1, 2'b00);
      // random traffic
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 199) == 0);
         cyc($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 6,
             ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
      end
      rst = 1'b0;
      repeat (4) cyc(1'b0, 32'h0, 1'b1, 2'b00);
      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
